// File: rtl/secded_stream_codec.sv
// SECDED (extended Hamming) stream encoder/decoder, per-beat mode; SECDED_ERR_CNT_EN builds error counters.
// Latency: 2 cycles from input acceptance to out_valid, 1 beat/cycle throughput.
// Backpressure: out_ready low freezes stage 2; in_ready drops only when both stages hold beats.
module secded_stream_codec #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int PAR_W = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1),
    localparam int CW_W  = DATA_WIDTH + PAR_W + 1,
    localparam int POS_W = $clog2(CW_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [CW_W-1:0]      in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW_W-1:0]      out_word,
    output logic                 out_mode,
    output logic                 out_single_err,
    output logic                 out_double_err,
    output logic [POS_W-1:0]     out_err_pos,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);

    // Index i maps to Hamming position i+1; non-power-of-two positions carry data LSB first.
    function automatic logic [CW_W-1:0] f_encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW_W-1:0]  cw;
        logic [PAR_W-1:0] syn;
        int               j;
        cw  = '0;
        syn = '0;
        j   = 0;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                cw[i] = d[j];
                if (d[j]) syn ^= PAR_W'(i + 1);
                j++;
            end
        end
        for (int k = 0; k < PAR_W; k++) cw[(1 << k) - 1] = syn[k];
        cw[CW_W-1] = ^cw[CW_W-2:0];
        return cw;
    endfunction

    function automatic logic [PAR_W-1:0] f_syndrome(input logic [CW_W-1:0] cw);
        logic [PAR_W-1:0] syn;
        syn = '0;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (cw[i]) syn ^= PAR_W'(i + 1);
        end
        return syn;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_extract(input logic [CW_W-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int                    j;
        d = '0;
        j = 0;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    logic                  r_s1_vld;
    logic                  r_s1_mode;
    logic [CW_W-1:0]       r_s1_word;
    logic [PAR_W-1:0]      r_s1_syn;
    logic                  r_s1_par;

    logic                  r_out_vld;
    logic                  r_out_mode;
    logic [CW_W-1:0]       r_out_word;
    logic                  r_out_single;
    logic                  r_out_double;
    logic [POS_W-1:0]      r_out_pos;

    logic                  w_s2_load;
    logic [CW_W-1:0]       w_cw;
    logic [CW_W-1:0]       w_res;
    logic                  w_single;
    logic                  w_double;
    logic [POS_W-1:0]      w_pos;

    assign w_s2_load = !r_out_vld || out_ready;
    assign in_ready  = !r_s1_vld || w_s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_word <= '0;
            r_s1_syn  <= '0;
            r_s1_par  <= 1'b0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_mode <= in_mode;
                r_s1_word <= in_word;
                r_s1_syn  <= f_syndrome(in_word);
                r_s1_par  <= ^in_word;
            end
        end
    end

    always_comb begin
        w_cw     = r_s1_word;
        w_res    = '0;
        w_single = 1'b0;
        w_double = 1'b0;
        w_pos    = '0;
        if (!r_s1_mode) begin
            w_res = f_encode(r_s1_word[DATA_WIDTH-1:0]);
        end else begin
            if (r_s1_syn == '0) begin
                if (r_s1_par) begin
                    w_single = 1'b1;
                    w_pos    = POS_W'(CW_W - 1);
                end
            end else if (r_s1_par && (int'(r_s1_syn) <= CW_W - 1)) begin
                w_single = 1'b1;
                w_pos    = POS_W'(int'(r_s1_syn) - 1);
                for (int i = 0; i < CW_W - 1; i++) begin
                    if (int'(r_s1_syn) == i + 1) w_cw[i] = ~w_cw[i];
                end
            end else begin
                w_double = 1'b1;
            end
            w_res = {{(CW_W-DATA_WIDTH){1'b0}}, f_extract(w_cw)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld    <= 1'b0;
            r_out_mode   <= 1'b0;
            r_out_word   <= '0;
            r_out_single <= 1'b0;
            r_out_double <= 1'b0;
            r_out_pos    <= '0;
        end else if (w_s2_load) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_mode   <= r_s1_mode;
                r_out_word   <= w_res;
                r_out_single <= w_single;
                r_out_double <= w_double;
                r_out_pos    <= w_pos;
            end
        end
    end

    assign out_valid      = r_out_vld;
    assign out_mode       = r_out_mode;
    assign out_word       = r_out_word;
    assign out_single_err = r_out_single;
    assign out_double_err = r_out_double;
    assign out_err_pos    = r_out_pos;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_corr_cnt;
    logic [CNT_WIDTH-1:0] r_uncorr_cnt;
    logic                 w_fire;

    assign w_fire = r_out_vld && out_ready && r_out_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_fire) begin
            if (r_out_single && !(&r_corr_cnt))   r_corr_cnt   <= r_corr_cnt + 1'b1;
            if (r_out_double && !(&r_uncorr_cnt)) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;
    assign corr_cnt     = '0;
    assign uncorr_cnt   = '0;
`endif

endmodule

// File: tb/tb_secded_stream_codec.sv
// Directed bench for secded_stream_codec at DATA_WIDTH=8 (13-bit codeword), CNT_WIDTH=2.
module tb_secded_stream_codec;

    localparam int CW = 13;
`ifdef SECDED_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [CW-1:0] in_word = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_word;
    logic          out_mode;
    logic          out_single_err;
    logic          out_double_err;
    logic [3:0]    out_err_pos;
    logic          clr_cnt = 1'b0;
    logic [1:0]    corr_cnt;
    logic [1:0]    uncorr_cnt;

    int checks = 0;
    int errors = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;
    logic [CW-1:0] cap_q[$];

    always #5 clk = ~clk;

    secded_stream_codec #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mode        (in_mode),
        .in_word        (in_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_word       (out_word),
        .out_mode       (out_mode),
        .out_single_err (out_single_err),
        .out_double_err (out_double_err),
        .out_err_pos    (out_err_pos),
        .clr_cnt        (clr_cnt),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) cap_q.push_back(out_word);
    end

    // Expected counter value: saturating model when counters are built, else tied to zero.
    function automatic logic [1:0] ec(input int v);
        if (!CNT_EN) return 2'd0;
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipeline with out_ready=1; returns with its result on the outputs.
    task automatic beat(input logic mode, input logic [CW-1:0] word);
        in_valid = 1'b1;
        in_mode  = mode;
        in_word  = word;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_word !== 13'h0000) begin errors++; $display("FAIL reset_out_word got %h exp 0000", out_word); end
        checks++; if ({out_mode, out_single_err, out_double_err, out_err_pos} !== 7'd0) begin errors++; $display("FAIL reset_flags got %b exp 0", {out_mode, out_single_err, out_double_err, out_err_pos}); end
        checks++; if ({corr_cnt, uncorr_cnt} !== 4'd0) begin errors++; $display("FAIL reset_counters got %h exp 0", {corr_cnt, uncorr_cnt}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        step();
    endtask

    task automatic test_encode();
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_word  = 13'h00FF;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL enc_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_latency_c1 got %b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc_latency_c2 got %b exp 1", out_valid); end
        checks++; if (out_word !== 13'h0F77) begin errors++; $display("FAIL enc_ff_word got %h exp 0f77", out_word); end
        checks++; if ({out_mode, out_single_err, out_double_err, out_err_pos} !== 7'd0) begin errors++; $display("FAIL enc_ff_flags got %b exp 0", {out_mode, out_single_err, out_double_err, out_err_pos}); end
        step();
        // Upper input bits must be ignored on encode.
        beat(1'b0, 13'h1F01);
        checks++; if (out_word !== 13'h1007) begin errors++; $display("FAIL enc_01_word got %h exp 1007", out_word); end
        step();
        beat(1'b0, 13'h0000);
        checks++; if (out_word !== 13'h0000) begin errors++; $display("FAIL enc_00_word got %h exp 0000", out_word); end
        step();
    endtask

    task automatic test_decode_clean();
        beat(1'b1, 13'h0F77);
        checks++; if (out_word !== 13'h00FF) begin errors++; $display("FAIL clean_word got %h exp 00ff", out_word); end
        checks++; if ({out_mode, out_single_err, out_double_err, out_err_pos} !== 7'b1000000) begin errors++; $display("FAIL clean_flags got %b exp 1000000", {out_mode, out_single_err, out_double_err, out_err_pos}); end
        step();
    endtask

    task automatic test_single();
        beat(1'b1, 13'h0F67);
        checks++; if (out_word !== 13'h00FF) begin errors++; $display("FAIL single_word got %h exp 00ff", out_word); end
        checks++; if ({out_mode, out_single_err, out_double_err} !== 3'b110) begin errors++; $display("FAIL single_flags got %b exp 110", {out_mode, out_single_err, out_double_err}); end
        checks++; if (out_err_pos !== 4'd4) begin errors++; $display("FAIL single_pos got %0d exp 4", out_err_pos); end
        step();
        exp_corr++;
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL single_corr_cnt got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    task automatic test_overall_parity();
        beat(1'b1, 13'h1F77);
        checks++; if (out_word !== 13'h00FF) begin errors++; $display("FAIL ovp_word got %h exp 00ff", out_word); end
        checks++; if ({out_single_err, out_double_err} !== 2'b10) begin errors++; $display("FAIL ovp_flags got %b exp 10", {out_single_err, out_double_err}); end
        checks++; if (out_err_pos !== 4'd12) begin errors++; $display("FAIL ovp_pos got %0d exp 12", out_err_pos); end
        step();
        exp_corr++;
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL ovp_corr_cnt got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    task automatic test_double();
        beat(1'b1, 13'h0F74);
        checks++; if ({out_single_err, out_double_err} !== 2'b01) begin errors++; $display("FAIL double_flags got %b exp 01", {out_single_err, out_double_err}); end
        checks++; if (out_err_pos !== 4'd0) begin errors++; $display("FAIL double_pos got %0d exp 0", out_err_pos); end
        checks++; if (out_word !== 13'h00FF) begin errors++; $display("FAIL double_word got %h exp 00ff", out_word); end
        step();
        exp_uncorr++;
        checks++; if (uncorr_cnt !== ec(exp_uncorr)) begin errors++; $display("FAIL double_uncorr_cnt got %0d exp %0d", uncorr_cnt, ec(exp_uncorr)); end
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL double_corr_cnt got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_word   = 13'h00FF;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_s1 got %b exp 1", in_ready); end
        in_mode = 1'b1;
        in_word = 13'h0F67;
        step();
        checks++; if (out_valid !== 1'b1 || out_word !== 13'h0F77) begin errors++; $display("FAIL b2b_first_out got vld %b word %h exp vld 1 word 0f77", out_valid, out_word); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
        in_mode = 1'b0;
        in_word = 13'h0001;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cycle %0d got %b exp 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_word !== 13'h0F77 || out_mode !== 1'b0) begin errors++; $display("FAIL b2b_stall_hold cycle %0d got vld %b word %h mode %b", c, out_valid, out_word, out_mode); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_comb got %b exp 1", in_ready); end
        step();
        checks++; if (out_word !== 13'h00FF || out_mode !== 1'b1 || out_single_err !== 1'b1) begin errors++; $display("FAIL b2b_second_out got word %h mode %b single %b exp 00ff 1 1", out_word, out_mode, out_single_err); end
        in_mode = 1'b1;
        in_word = 13'h1007;
        step();
        in_valid = 1'b0;
        step();
        step();
        exp_corr++;
        checks++; if (cap_q.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", cap_q.size()); end
        if (cap_q.size() == 4) begin
            checks++; if (cap_q[0] !== 13'h0F77) begin errors++; $display("FAIL b2b_beat0 got %h exp 0f77", cap_q[0]); end
            checks++; if (cap_q[1] !== 13'h00FF) begin errors++; $display("FAIL b2b_beat1 got %h exp 00ff", cap_q[1]); end
            checks++; if (cap_q[2] !== 13'h1007) begin errors++; $display("FAIL b2b_beat2 got %h exp 1007", cap_q[2]); end
            checks++; if (cap_q[3] !== 13'h0001) begin errors++; $display("FAIL b2b_beat3 got %h exp 0001", cap_q[3]); end
        end
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL b2b_corr_cnt got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_word   = 13'h0F67;
        step();
        in_mode = 1'b0;
        in_word = 13'h00FF;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b exp 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_corr   = 0;
        exp_uncorr = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (out_word !== 13'h0000 || {out_mode, out_single_err, out_double_err, out_err_pos} !== 7'd0) begin errors++; $display("FAIL mid_outputs got word %h flags %b exp 0", out_word, {out_mode, out_single_err, out_double_err, out_err_pos}); end
        checks++; if ({corr_cnt, uncorr_cnt} !== 4'd0) begin errors++; $display("FAIL mid_counters got %h exp 0", {corr_cnt, uncorr_cnt}); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release got rdy %b vld %b exp 1 0", in_ready, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", out_valid); end
    endtask

    task automatic test_saturation();
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_word  = 13'h0F67;
        for (int b = 0; b < 5; b++) step();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) step();
        exp_corr += 5;
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL sat_corr_cnt got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    task automatic test_clear();
        beat(1'b1, 13'h0F67);
        clr_cnt = 1'b1;
        step();
        clr_cnt  = 1'b0;
        exp_corr = 0;
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL clr_priority got %0d exp %0d", corr_cnt, ec(exp_corr)); end
        beat(1'b1, 13'h0F67);
        step();
        exp_corr++;
        checks++; if (corr_cnt !== ec(exp_corr)) begin errors++; $display("FAIL clr_resume got %0d exp %0d", corr_cnt, ec(exp_corr)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_encode();
        test_decode_clean();
        test_single();
        test_overall_parity();
        test_double();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_stream_codec.md
# secded_stream_codec

Parametrised, pipelined SECDED (extended Hamming) encoder/decoder with valid/ready streaming on both sides, per-beat mode select and optional saturating error statistics. It is the general-width successor of the fixed 8-bit extended Hamming codec. It sits between a datapath producer and a storage or link interface, and the encode and decode paths share one two-stage pipeline.

## Interface
- DATA_WIDTH, 32: payload bits, 4..64.
- CNT_WIDTH, 16: width of each error counter.
- PAR_W (localparam): smallest r with 2^r >= DATA_WIDTH+r+1.
- CW_W (localparam): DATA_WIDTH+PAR_W+1, the codeword width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  1  0 = encode, 1 = decode.
- in_word  in  CW_W  encode: payload in [DATA_WIDTH-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_word  out  CW_W  encode: codeword; decode: corrected payload in low bits, upper bits zero.
- out_mode  out  1  mode of the beat.
- out_single_err  out  1  decode: a single error was corrected.
- out_double_err  out  1  decode: an uncorrectable error was detected.
- out_err_pos  out  $clog2(CW_W)  index of the corrected bit; 0 if none.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_WIDTH  count of corrected beats.
- uncorr_cnt  out  CNT_WIDTH  count of uncorrectable beats.

## Operation
- Code layout: codeword index i corresponds to Hamming position i+1 for i < CW_W-1.
  - Positions that are powers of two hold parity bits.
  - Data bits fill the remaining positions in ascending order, LSB first.
  - Index CW_W-1 holds the overall parity bit.
- Parity bit at position 2^k = XOR of the bits at all positions with bit k set, excluding itself.
- Overall parity = XOR of indices 0..CW_W-2, so the full codeword has even parity.
- Decode computes syndrome s = XOR of (i+1) over all set bits i < CW_W-1, with the parity bits included. It also computes p = XOR of all CW_W bits.
  - s=0, p=0: no error.
  - s=0, p=1: overall parity bit is in error. Flag single, err_pos=CW_W-1, payload unchanged.
  - s≠0, p=1, s<=CW_W-1: flip index s-1. Flag single, err_pos=s-1.
  - s≠0, p=1, s>CW_W-1: flag double; payload is extracted uncorrected.
  - s≠0, p=0: flag double; payload is extracted uncorrected.
- Single and double flags are mutually exclusive. Both are 0 for encode beats.
- Counters:
  - Each counter increments once per decode beat leaving the output (out_valid && out_ready) with the corresponding flag set.
  - Counters saturate at all-ones.
  - clr_cnt has priority over increment in the same cycle.

## Timing
- Stage 1 registers the input word, mode, syndrome and p. Stage 2 registers the corrected or encoded result and the flags.
- Latency is 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stage 2 loads when it is empty or out_ready=1. Stage 1 advances under the same condition.
- in_ready = !s1_valid || !out_valid || out_ready. This is combinational from out_ready; no bubble is inserted.
- While out_valid && !out_ready, all out_* signals hold stable.
- Mode may change on every beat. The results of a beat always carry that beat's mode.
- Reset (asynchronous, any time):
  - Both stage valids drop, so out_valid=0.
  - out_word, out_mode, out_single_err, out_double_err, out_err_pos = 0.
  - Counters = 0.
  - in_ready=1 on the first cycle after release.
  - Beats in flight are discarded.

## Configuration
- SECDED_ERR_CNT_EN
  - Defined: corr_cnt/uncorr_cnt counters and the clr_cnt logic are built.
  - Undefined: counters are not built; corr_cnt and uncorr_cnt are tied to 0 and clr_cnt is ignored. All other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=8, so CW_W=13.
- Encode 0xFF -> out_word 0x0F77, flags 0, out_valid two cycles after acceptance.
- Decode 0x0F67 (index 4 flipped) -> payload 0xFF, single=1, err_pos=4, corr_cnt +1.
- Decode 0x1F77 (overall parity flipped) -> payload 0xFF, single=1, err_pos=12.
- Decode 0x0F74 (indices 0 and 1 flipped) -> double=1, single=0, uncorr_cnt +1, corr_cnt unchanged.
- Back-to-back encode/decode beats with out_ready held low for 3 cycles:
  - out_* stable while stalled;
  - in_ready=0 once both stages are full;
  - no beats lost or duplicated; order preserved.
- Reset asserted mid-stream with 2 beats in flight -> outputs and counters 0 immediately.
- Counter saturation and clear:
  - CNT_WIDTH=2, 5 single-error beats -> corr_cnt saturates at 3.
  - clr_cnt coincident with an increment -> corr_cnt 0.
